muldiv_sequencer: RTL
=====================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter: W, default 8, operand width; equals the shared arithmetic unit width.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: start  in  1  request pulse; sampled only in IDLE.
REQ-005 Port: op  in  1  0 = unsigned multiply, 1 = unsigned divide; sampled with start.
REQ-006 Port: opa  in  W  multiplicand or dividend; sampled with start.
REQ-007 Port: opb  in  W  multiplier or divisor; sampled with start.
REQ-008 Port: busy  out  1  high while the operation is in progress (RUN).
REQ-009 Port: done  out  1  one-cycle pulse; results valid.
REQ-010 Port: res_hi  out  W  product[15:8] (mul) or remainder (div).
REQ-011 Port: res_lo  out  W  product[7:0] (mul) or quotient (div).
REQ-012 Port: dz  out  1  divide-by-zero flag for the last operation.

Function
REQ-013 The block SHALL have states IDLE, RUN and DONE.
REQ-014 In IDLE with start=1, the block SHALL latch op/opa/opb, clear the accumulator, load iteration count 0 and go to RUN.
REQ-015 In IDLE with start=1, op=1 and opb=0, the block SHALL skip RUN and go to DONE with dz=1, res_lo=8'hFF, res_hi=opa.
REQ-016 RUN SHALL last exactly W cycles, one iteration per cycle; after the W-th iteration the state SHALL go to DONE.
REQ-017 Multiply iteration: if Q[0]=1, the shared adder in add mode SHALL form {C,A}=A+M; otherwise {C,A}={0,A}; then {C,A,Q} SHALL shift right by one.
REQ-018 Divide iteration: {R,Q} SHALL shift left by one, with the shifted-out R MSB kept as bit s; the shared adder in subtract mode SHALL form R−D.
REQ-019 Divide iteration: if the adder carry=1 (no borrow) or s=1, then R SHALL take the adder result and Q[0]=1; otherwise R SHALL be unchanged and Q[0]=0.
REQ-020 The adder add input SHALL be 1 for multiply and 0 for divide; r2 SHALL carry A/R and r1 SHALL carry M/D.
REQ-021 The adder overflow output SHALL be ignored.
REQ-022 DONE SHALL last one cycle with done=1 and then return to IDLE; res_hi, res_lo and dz SHALL hold until the next accepted start.
REQ-023 busy SHALL be 1 in RUN only.
REQ-024 start outside IDLE, including in DONE, SHALL be ignored and SHALL NOT be queued.
REQ-025 Latency from start accepted at cycle 0 SHALL be: done at cycle W+1; on the divide-by-zero path, done at cycle 1.
REQ-026 res_hi and res_lo SHALL update only on the transition into DONE.
REQ-027 dz SHALL be cleared on the transition into DONE for any non-zero-divisor operation.

Reset
REQ-028 rst=1 SHALL force IDLE and busy=done=dz=0, res_hi=res_lo=0, and clear the counter and working registers.
REQ-029 rst during RUN SHALL abort the operation with no done pulse; rst has priority over start.

Structure
REQ-030 A shared package SHALL hold the W and ITER constants, the state enum (IDLE/RUN/DONE) and the op enum (OP_MUL/OP_DIV).
REQ-031 The existing 8-bit add/subtract arithmetic unit SHALL be the single instantiated sub-module.
REQ-032 The arithmetic unit SHALL NOT be duplicated, and no other adder SHALL exist besides the 3-bit iteration counter.

Verification
REQ-033 mul 13×11 -> done at cycle 9; res_hi=8'h00, res_lo=8'h8F; dz=0.
REQ-034 mul 255×255 -> res_hi=8'hFE, res_lo=8'h01; carry path exercised.
REQ-035 div 200/7 -> res_lo=28, res_hi=4; div 255/1 -> res_lo=255, res_hi=0; div 129/200 -> res_lo=0, res_hi=129.
REQ-036 div 37/0 -> done at cycle 1; dz=1, res_lo=8'hFF, res_hi=37; busy never high.
REQ-037 start pulses during RUN and during DONE -> ignored; result equals the first operation's result; exactly one done pulse.
REQ-038 rst asserted at RUN cycle 4 -> next cycle IDLE with all outputs 0 and no done; a new mul 3×5 then yields 15.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// Shared constants and enums for the multiply/divide sequencer.
//   W     : operand width, equal to the shared add/subtract unit width
//   ITER  : iterations per operation (one result bit per RUN cycle)
//   state_e : sequencer states
//   op_e    : operation select carried on the request bus
package muldiv_sequencer_pkg;

  localparam int W    = 8;
  localparam int ITER = W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/result bus of the multiply/divide sequencer.
//   start, op, opa, opb : request (master -> slave), sampled when the sequencer is idle
//   busy                : operation in progress
//   done                : one-cycle result-valid pulse
//   res_hi, res_lo      : product high/low byte, or remainder/quotient
//   dz                  : divide-by-zero flag of the last operation
interface muldiv_sequencer_if
  import muldiv_sequencer_pkg::*;
#(
  parameter int W = 8
) ();

  logic         start;
  op_e          op;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         busy;
  logic         done;
  logic [W-1:0] res_hi;
  logic [W-1:0] res_lo;
  logic         dz;

  modport master (
    output start, op, opa, opb,
    input  busy, done, res_hi, res_lo, dz
  );

  modport slave (
    input  start, op, opa, opb,
    output busy, done, res_hi, res_lo, dz
  );

endinterface

// File: rtl/muldiv_sequencer_alu.sv
// Shared add/subtract unit.
//   add   : 1 = r2 + r1, 0 = r2 - r1 (two's complement, carry=1 means no borrow)
//   r1/r2 : operands
//   sum   : W-bit result
//   carry : carry out (add) / not-borrow (subtract)
//   ovf   : signed overflow of the operation
module muldiv_sequencer_alu #(
  parameter int W = 8
) (
  input  logic         add,
  input  logic [W-1:0] r1,
  input  logic [W-1:0] r2,
  output logic [W-1:0] sum,
  output logic         carry,
  output logic         ovf
);

  logic [W-1:0] r1_inv;
  logic [W:0]   ext;

  always_comb begin
    // Subtract is r2 + ~r1 + 1 so one carry chain serves both modes.
    r1_inv = add ? r1 : ~r1;
    ext    = {1'b0, r2} + {1'b0, r1_inv} + {{W{1'b0}}, ~add};
    sum    = ext[W-1:0];
    carry  = ext[W];
    ovf    = (r2[W-1] == r1_inv[W-1]) && (sum[W-1] != r2[W-1]);
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequential unsigned multiply / restoring divide, one result bit per cycle,
// sharing a single add/subtract unit.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of muldiv_sequencer_if (request in, result out)
// Multiply: acc/q hold {A,Q}, m holds M; product ends up as {acc,q}.
// Divide:   acc/q hold {R,Q}, m holds D; remainder in acc, quotient in q.
module muldiv_sequencer #(
  parameter int W = muldiv_sequencer_pkg::W
) (
  input  logic              clk,
  input  logic              rst,
  muldiv_sequencer_if.slave bus
);

  import muldiv_sequencer_pkg::*;

  localparam int CNT_W = $clog2(W);

  state_e           state, state_nxt;
  op_e              op_r;
  logic [W-1:0]     acc, q, m;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     res_hi_r, res_lo_r;
  logic             dz_r;

  logic             accept, dz_take, last_iter;
  logic             alu_add, alu_carry, alu_ovf_unused;
  logic [W-1:0]     alu_r2, alu_sum;
  logic [W-1:0]     shl;
  logic             s_bit;
  logic [W:0]       a_pre;
  logic [W-1:0]     acc_nxt, q_nxt;

  muldiv_sequencer_alu #(.W(W)) u_alu (
    .add   (alu_add),
    .r1    (m),
    .r2    (alu_r2),
    .sum   (alu_sum),
    .carry (alu_carry),
    .ovf   (alu_ovf_unused)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    dz_take   = 1'b0;
    last_iter = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept = 1'b1;
          // A zero divisor bypasses RUN entirely.
          if (bus.op == OP_DIV && bus.opb == '0) begin
            dz_take   = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (cnt == CNT_W'(W - 1)) begin
          last_iter = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    alu_add = (op_r == OP_MUL);
    shl     = {acc[W-2:0], q[W-1]};
    s_bit   = acc[W-1];
    alu_r2  = (op_r == OP_MUL) ? acc : shl;
    a_pre   = '0;
    acc_nxt = acc;
    q_nxt   = q;
    if (op_r == OP_MUL) begin
      // {C,A} then a right shift of {C,A,Q}; C lands in the MSB of A.
      a_pre   = q[0] ? {alu_carry, alu_sum} : {1'b0, acc};
      acc_nxt = a_pre[W:1];
      q_nxt   = {a_pre[0], q[W-1:1]};
    end else begin
      // s_bit set means the shifted remainder is >= 2^W, hence >= D.
      if (alu_carry || s_bit) begin
        acc_nxt = alu_sum;
        q_nxt   = {q[W-2:0], 1'b1};
      end else begin
        acc_nxt = shl;
        q_nxt   = {q[W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_r     <= OP_MUL;
      acc      <= '0;
      q        <= '0;
      m        <= '0;
      cnt      <= '0;
      res_hi_r <= '0;
      res_lo_r <= '0;
      dz_r     <= 1'b0;
    end else begin
      if (accept) begin
        op_r <= bus.op;
        acc  <= '0;
        cnt  <= '0;
        if (bus.op == OP_MUL) begin
          m <= bus.opa;
          q <= bus.opb;
        end else begin
          m <= bus.opb;
          q <= bus.opa;
        end
      end else if (state == RUN) begin
        acc <= acc_nxt;
        q   <= q_nxt;
        cnt <= cnt + CNT_W'(1);
      end
      if (dz_take) begin
        res_hi_r <= bus.opa;
        res_lo_r <= '1;
        dz_r     <= 1'b1;
      end else if (last_iter) begin
        res_hi_r <= acc_nxt;
        res_lo_r <= q_nxt;
        dz_r     <= 1'b0;
      end
    end
  end

  assign bus.busy   = (state == RUN);
  assign bus.done   = (state == DONE);
  assign bus.res_hi = res_hi_r;
  assign bus.res_lo = res_lo_r;
  assign bus.dz     = dz_r;

endmodule
